pipelined_binary_adder: RTL and testbench
=========================================

// Module: pipelined_binary_adder
// PURPOSE
//  Parametrised WIDTH-bit adder that adds a + b + cin.
//  The carry chain is split into CHUNK-bit slices, with one register stage per slice.
//  A valid/ready handshake sits on both input and output.
//  Successor of the fixed 4-bit combinational adder, for wide datapaths where a
//  full-width ripple carry misses timing.
// PARAMETERS
//  WIDTH   16  operand/sum width in bits; must be a multiple of CHUNK.
//  CHUNK   4   bits added per pipeline stage.
//  STAGES = WIDTH/CHUNK. This is derived, not overridable, and sets the latency.
// PORTS
//  clk        in   1      single clock; all state on rising edge.
//  rst        in   1      asynchronous, active-high reset.
//  in_valid   in   1      a/b/cin valid this cycle.
//  in_ready   out  1      block can accept; transfer when in_valid&&in_ready.
//  a          in   WIDTH  operand A (unsigned; two's-complement for ovf).
//  b          in   WIDTH  operand B.
//  cin        in   1      carry in to bit 0.
//  out_valid  out  1      sum/cout valid.
//  out_ready  in   1      sink accepts; transfer when out_valid&&out_ready.
//  sum        out  WIDTH  (a+b+cin) mod 2^WIDTH.
//  cout       out  1      carry out of bit WIDTH-1.
//  ovf        out  1      signed overflow; present only with OVERFLOW_FLAG_EN.
// BEHAVIOUR
//  Reset (async assert, sync release): all stage valids=0; out_valid=0;
//   sum=0; cout=0; ovf=0. in_ready=1 as soon as rst deasserts.
//  Pipeline: stage k (0..STAGES-1) adds slice k of a/b with the carry
//   registered from stage k-1 (stage 0 uses cin).
//   Upper operand slices and lower sum slices travel alongside as skew registers.
//  Stall: advance = !out_valid || out_ready. All stages shift only when
//   advance=1. in_ready = advance, so this is a global stall.
//  Latency: result is on sum/cout exactly STAGES cycles after acceptance,
//   with no stall in between. Throughput is 1 op/cycle.
//  While out_valid=1 and out_ready=0: sum/cout/ovf/out_valid are held stable.
//   Nothing is lost and nothing is duplicated.
//  Bubbles (in_valid=0 when advancing) propagate as valid=0 stages.
//   Data registers in bubble stages may update freely (don't-care).
//  Order: results leave strictly in acceptance order.
//  Wrap-around: a=all-ones, b=0, cin=1 gives sum=0 and cout=1.
//  Simultaneous out accept + in accept in the same cycle is legal and
//   sustains full throughput.
//  Reset mid-operation: all in-flight ops are discarded, with no partial
//   result emitted after release.
//  Inputs a/b/cin are sampled only on accepted cycles.
//  No combinational path from a/b to sum.
//  The only combinational path is out_ready -> in_ready.
// CONFIGURATION
//  OVERFLOW_FLAG_EN defined:
//   ovf port exists.
//   ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]), with cin included in the sum.
//   Timed with sum; reset 0; held during stall.
//  OVERFLOW_FLAG_EN undefined:
//   ovf port and its sign-tracking registers are absent.
//   All other behaviour is identical.
// TESTING  (WIDTH=16, CHUNK=4 -> STAGES=4)
//  1. rst=1 mid-run
//     -> out_valid=0, sum=0, cout=0 immediately (async).
//     -> After release, in_ready=1 and no stale result appears.
//  2. a=16'hFFFF b=16'h0001 cin=0, out_ready=1
//     -> 4 cycles later out_valid=1, sum=16'h0000, cout=1.
//  3. Back-to-back (1234+1111+0), (8000+8000+1), (00FF+0001+0)
//     -> consecutive cycles: 2345/c0, 0001/c1, 0100/c0.
//  4. Pipeline full, out_ready=0 for 5 cycles
//     -> in_ready=0, sum/cout held.
//     -> out_ready=1 releases one result per cycle; no loss or duplication.
//  5. OVERFLOW_FLAG_EN: a=16'h7FFF b=16'h0001 cin=0
//     -> sum=8000, ovf=1.
//     a=16'hFFFF b=16'hFFFF
//     -> sum=FFFE, cout=1, ovf=0.
//  6. Random 1000 ops with random in_valid/out_ready
//     -> every result matches a scoreboard of {cout,sum}=a+b+cin.

Source files
------------

// File: rtl/pipelined_binary_adder.sv
// -----------------------------------------------------------------------------
// pipelined_binary_adder
//   WIDTH-bit adder computing a + b + cin. The carry chain is cut into
//   CHUNK-bit slices, and each slice has its own register stage, so latency is
//   STAGES = WIDTH/CHUNK cycles. The bench sees one result per cycle.
//   Valid/ready handshakes sit on the input and the output. A stall at the
//   output freezes every stage at once, so the stall is global.
//
// Optional feature macro: OVERFLOW_FLAG_EN
//   When defined, this macro adds the ovf port. ovf is the two's-complement
//   overflow flag and is timed with sum.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      a/b/cin valid
//   in_ready   out  1      block can accept (combinational from out_ready)
//   a, b       in   WIDTH  operands
//   cin        in   1      carry into bit 0
//   out_valid  out  1      sum/cout valid
//   out_ready  in   1      sink accepts
//   sum        out  WIDTH  (a+b+cin) mod 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
//   ovf        out  1      signed overflow (OVERFLOW_FLAG_EN only)
// -----------------------------------------------------------------------------
module pipelined_binary_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned LAST   = STAGES - 1;
  localparam int unsigned SW     = CHUNK + 1;

  // Per-stage pipeline registers. Each stage keeps the upper operand bits
  // still to be added, the sum bits produced so far, and the carry.
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_c;
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];

  // Stage inputs and next values.
  logic [WIDTH-1:0]  w_a_src [STAGES];
  logic [WIDTH-1:0]  w_b_src [STAGES];
  logic [WIDTH-1:0]  w_s_src [STAGES];
  logic [WIDTH-1:0]  w_s_nxt [STAGES];
  logic [SW-1:0]     w_slice [STAGES];
  logic [STAGES-1:0] w_c_src;
  logic [STAGES-1:0] w_c_nxt;
  logic              w_advance;

`ifdef OVERFLOW_FLAG_EN
  logic              r_ovf;
`endif

  // Global stall: everything moves only when the output slot frees up.
  assign w_advance = !r_vld[LAST] || out_ready;
  assign in_ready  = w_advance;

  // One CHUNK-bit slice addition per stage; stage 0 is fed from the ports.
  always_comb begin
    w_a_src[0] = a;
    w_b_src[0] = b;
    w_s_src[0] = '0;
    w_c_src[0] = cin;
    for (int unsigned k = 1; k < STAGES; k++) begin
      w_a_src[k] = r_a[k-1];
      w_b_src[k] = r_b[k-1];
      w_s_src[k] = r_s[k-1];
      w_c_src[k] = r_c[k-1];
    end
    for (int unsigned k = 0; k < STAGES; k++) begin
      w_slice[k] = SW'(w_a_src[k][k*CHUNK +: CHUNK])
                 + SW'(w_b_src[k][k*CHUNK +: CHUNK])
                 + SW'(w_c_src[k]);
      w_s_nxt[k] = w_s_src[k];
      w_s_nxt[k][k*CHUNK +: CHUNK] = w_slice[k][CHUNK-1:0];
      w_c_nxt[k] = w_slice[k][CHUNK];
    end
  end

  // Pipeline registers. Stage-0 data is loaded only on accepted cycles.
  // Bubble data in later stages is don't-care.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_c   <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
`ifdef OVERFLOW_FLAG_EN
      r_ovf <= 1'b0;
`endif
    end else if (w_advance) begin
      r_vld[0] <= in_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (k != 0 || in_valid) begin
          r_s[k] <= w_s_nxt[k];
          r_c[k] <= w_c_nxt[k];
          // The last stage has no further slices, so it drops its operands.
          if (k < LAST) begin
            r_a[k] <= w_a_src[k];
            r_b[k] <= w_b_src[k];
          end
        end
      end
`ifdef OVERFLOW_FLAG_EN
      // Overflow means both operand signs match and differ from the final sign bit.
      r_ovf <= (w_a_src[LAST][WIDTH-1] == w_b_src[LAST][WIDTH-1])
            && (w_s_nxt[LAST][WIDTH-1] != w_a_src[LAST][WIDTH-1]);
`endif
    end
  end

  assign sum       = r_s[LAST];
  assign cout      = r_c[LAST];
  assign out_valid = r_vld[LAST];
`ifdef OVERFLOW_FLAG_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_binary_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_binary_adder
//   Directed and random checks of pipelined_binary_adder with WIDTH=16 and
//   CHUNK=4, which gives a latency of 4. OVERFLOW_FLAG_EN also enables the
//   ovf checks.
// -----------------------------------------------------------------------------
module tb_pipelined_binary_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef OVERFLOW_FLAG_EN
  logic        ovf;
`endif

  int n_pass  = 0;
  int n_total = 0;

  pipelined_binary_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef OVERFLOW_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #12;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (sum !== 16'h0000) $display("FAIL reset_sum got %h want 0000", sum); else n_pass++;
    n_total++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else n_pass++;
`ifdef OVERFLOW_FLAG_EN
    n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else n_pass++;
`endif
    @(negedge clk); rst = 1'b0;
    tick();
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL wrap_in_ready got %b want 1", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0; a = 16'h5A5A; b = 16'hA5A5;
    tick(); tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL wrap_early_valid got %b want 0", out_valid); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL wrap_latency_valid got %b want 1", out_valid); else n_pass++;
    n_total++; if (sum !== 16'h0000) $display("FAIL wrap_sum got %h want 0000", sum); else n_pass++;
    n_total++; if (cout !== 1'b1) $display("FAIL wrap_cout got %b want 1", cout); else n_pass++;
    // all-ones + 0 + cin=1 wraps to zero with carry out
    a = 16'hFFFF; b = 16'h0000; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; cin = 1'b0;
    tick(); tick(); tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL wrap2_valid got %b want 1", out_valid); else n_pass++;
    n_total++; if ({cout, sum} !== 17'h1_0000) $display("FAIL wrap2_result got %b/%h want 1/0000", cout, sum); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL wrap2_drain got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 16'h1234; b = 16'h1111; cin = 1'b0; tick();
    a = 16'h8000; b = 16'h8000; cin = 1'b1; tick();
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; tick();
    in_valid = 1'b0;
    tick();
    n_total++; if ({out_valid, cout, sum} !== {1'b1, 1'b0, 16'h2345}) $display("FAIL b2b_0 got v%b c%b %h want v1 c0 2345", out_valid, cout, sum); else n_pass++;
    tick();
    n_total++; if ({out_valid, cout, sum} !== {1'b1, 1'b1, 16'h0001}) $display("FAIL b2b_1 got v%b c%b %h want v1 c1 0001", out_valid, cout, sum); else n_pass++;
    tick();
    n_total++; if ({out_valid, cout, sum} !== {1'b1, 1'b0, 16'h0100}) $display("FAIL b2b_2 got v%b c%b %h want v1 c0 0100", out_valid, cout, sum); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 16'h0001; b = 16'h0002; cin = 1'b0; tick();
    a = 16'hABCD; b = 16'h1234; cin = 1'b1; tick();
    a = 16'hF000; b = 16'h1000; cin = 1'b0; tick();
    a = 16'h5555; b = 16'hAAAA; cin = 1'b1; tick();
    // The pipeline is full and the output is blocked, so the next op must wait.
    a = 16'h5555; b = 16'h0001; cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d] got %b want 0", i, in_ready); else n_pass++;
      n_total++; if ({out_valid, cout, sum} !== {1'b1, 1'b0, 16'h0003}) $display("FAIL stall_hold[%0d] got v%b c%b %h want v1 c0 0003", i, out_valid, cout, sum); else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL stall_release_ready got %b want 1", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_total++; if ({out_valid, cout, sum} !== {1'b1, 1'b0, 16'hBE02}) $display("FAIL stall_out1 got v%b c%b %h want v1 c0 BE02", out_valid, cout, sum); else n_pass++;
    tick();
    n_total++; if ({out_valid, cout, sum} !== {1'b1, 1'b1, 16'h0000}) $display("FAIL stall_out2 got v%b c%b %h want v1 c1 0000", out_valid, cout, sum); else n_pass++;
    tick();
    n_total++; if ({out_valid, cout, sum} !== {1'b1, 1'b1, 16'h0000}) $display("FAIL stall_out3 got v%b c%b %h want v1 c1 0000", out_valid, cout, sum); else n_pass++;
    tick();
    n_total++; if ({out_valid, cout, sum} !== {1'b1, 1'b0, 16'h5556}) $display("FAIL stall_out4 got v%b c%b %h want v1 c0 5556", out_valid, cout, sum); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL stall_drain got %b want 0", out_valid); else n_pass++;
  endtask

`ifdef OVERFLOW_FLAG_EN
  task automatic test_ovf();
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; tick();
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; tick();
    in_valid = 1'b0;
    tick(); tick();
    n_total++; if ({out_valid, cout, ovf, sum} !== {1'b1, 1'b0, 1'b1, 16'h8000}) $display("FAIL ovf_pos got v%b c%b o%b %h want v1 c0 o1 8000", out_valid, cout, ovf, sum); else n_pass++;
    tick();
    n_total++; if ({out_valid, cout, ovf, sum} !== {1'b1, 1'b1, 1'b0, 16'hFFFE}) $display("FAIL ovf_neg got v%b c%b o%b %h want v1 c1 o0 FFFE", out_valid, cout, ovf, sum); else n_pass++;
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; tick();
    a = 16'h4444; b = 16'h4444; cin = 1'b1; tick();
    in_valid = 1'b0;
    tick(); tick();
    n_total++; if ({out_valid, sum} !== {1'b1, 16'h3333}) $display("FAIL rstmid_pre got v%b %h want v1 3333", out_valid, sum); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++; if ({out_valid, cout, sum} !== {1'b0, 1'b0, 16'h0000}) $display("FAIL rstmid_async got v%b c%b %h want v0 c0 0000", out_valid, cout, sum); else n_pass++;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    out_ready = 1'b1;
    tick();
    n_total++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", in_ready); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_total++; if (out_valid !== 1'b0) $display("FAIL rstmid_stale[%0d] got %b want 0", i, out_valid); else n_pass++;
      tick();
    end
  endtask

  task automatic test_random();
    logic [16:0] exp_q[$];
    logic        exp_o[$];
    logic [16:0] r;
    logic [16:0] e;
    logic        eo;
    int          pushed = 0;
    int          popped = 0;
    int          cyc    = 0;
    int          errs   = 0;
    while (popped < 1000 && cyc < 20000) begin
      in_valid  = (pushed < 1000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      #1;
      if (out_valid && out_ready) begin
        e  = exp_q.pop_front();
        eo = exp_o.pop_front();
        popped++;
        n_total++;
`ifdef OVERFLOW_FLAG_EN
        if ({cout, sum, ovf} !== {e, eo}) begin
          errs++;
          if (errs <= 10) $display("FAIL random_op%0d got c%b %h o%b want c%b %h o%b", popped, cout, sum, ovf, e[16], e[15:0], eo);
        end else n_pass++;
`else
        if ({cout, sum} !== e) begin
          errs++;
          if (errs <= 10) $display("FAIL random_op%0d got c%b %h want c%b %h (ovf model %b)", popped, cout, sum, e[16], e[15:0], eo);
        end else n_pass++;
`endif
      end
      if (in_valid && in_ready) begin
        r = 17'(a) + 17'(b) + 17'(cin);
        exp_q.push_back(r);
        exp_o.push_back((a[15] == b[15]) && (r[15] != a[15]));
        pushed++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    n_total++;
    if (popped != 1000) $display("FAIL random_timeout got %0d results want 1000", popped);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_back_to_back();
    test_stall();
`ifdef OVERFLOW_FLAG_EN
    test_ovf();
`endif
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
